// File: rtl/store_checker_pkg.sv
// Shared types for the end-of-program store checker: FSM states and the
// trace entry layout {address, data}.
package store_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  localparam int LOG_ENTRY_W = 64;

  function automatic logic [LOG_ENTRY_W-1:0] pack_entry(input logic [31:0] adr,
                                                        input logic [31:0] data);
    return {adr, data};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and
// simultaneous push/pop; a pop while full frees the slot for a same-edge push.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage, pointers (wrapping naturally at DEPTH) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1'b1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1'b1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1'b1);
        2'b01:   r_count <= r_count - CW'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/store_checker.sv
// Watches the data-memory write bus for the result store, reports
// pass/fail/timeout and keeps a FIFO trace of every store made while running.
module store_checker
  import store_checker_pkg::*;
#(
  parameter logic [31:0] WATCH_ADDR     = 32'd160,
  parameter logic [31:0] EXPECT_DATA    = 32'h4202a40b,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          LOG_DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic [31:0]                DataAdr,
  input  logic [31:0]                WriteData,
  input  logic                       log_rd,
  output logic                       log_valid,
  output logic [31:0]                log_adr,
  output logic [31:0]                log_data,
  output logic [$clog2(LOG_DEPTH):0] log_count,
  output logic                       log_overflow,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [31:0]                captured_data,
  output logic [31:0]                cycle_count
);

  localparam int LW = $clog2(LOG_DEPTH) + 1;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_pass;
  logic                   r_fail;
  logic                   r_timeout;
  logic                   r_done;
  logic                   r_overflow;
  logic [31:0]            r_captured;
  logic [31:0]            r_cycle_count;
  logic                   w_store;
  logic                   w_hit;
  logic                   w_match;
  logic                   w_last;
  logic                   w_drop;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [LOG_ENTRY_W-1:0] w_head;
  logic [LW-1:0]          w_count;

  assign w_store = MemWrite & (r_state == ST_RUN);
  assign w_hit   = w_store & (DataAdr == WATCH_ADDR);
  assign w_match = (WriteData == EXPECT_DATA);
  assign w_last  = (r_cycle_count == 32'(TIMEOUT_CYCLES - 1));
  assign w_drop  = w_store & w_fifo_full & ~(log_rd & ~w_fifo_empty);

  // Next-state logic; a result store outranks a timeout on the same edge,
  // and an unknown data word falls through to the mismatch branch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: w_next_state = ST_RUN;
      ST_RUN: begin
        if (w_hit) begin
          if (w_match) begin
            w_next_state = ST_PASS;
          end else begin
            w_next_state = ST_FAIL;
          end
        end else if (w_last) begin
          w_next_state = ST_TIMEOUT;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: w_next_state = r_state;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, registered status flags, captured word, run counter, overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_timeout     <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
      r_captured    <= 32'd0;
      r_cycle_count <= 32'd0;
    end else begin
      r_state   <= w_next_state;
      r_pass    <= (w_next_state == ST_PASS);
      r_fail    <= (w_next_state == ST_FAIL);
      r_timeout <= (w_next_state == ST_TIMEOUT);
      r_done    <= (w_next_state == ST_PASS) | (w_next_state == ST_FAIL) |
                   (w_next_state == ST_TIMEOUT);
      if (r_state == ST_RUN) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
      if (w_hit) begin
        r_captured <= WriteData;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (LOG_ENTRY_W),
    .DEPTH (LOG_DEPTH)
  ) u_trace (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_store),
    .i_wdata (pack_entry(DataAdr, WriteData)),
    .i_pop   (log_rd),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign log_valid     = ~w_fifo_empty;
  assign log_adr       = w_head[63:32];
  assign log_data      = w_head[31:0];
  assign log_count     = w_count;
  assign log_overflow  = r_overflow;
  assign done          = r_done;
  assign pass          = r_pass;
  assign fail          = r_fail;
  assign timeout       = r_timeout;
  assign captured_data = r_captured;
  assign cycle_count   = r_cycle_count;

endmodule

// File: tb/tb_store_checker.sv
// Bench for store_checker: a queue scoreboard models the trace FIFO and run
// counter; status outcomes are checked against hand-derived constants.
module tb_store_checker;

  localparam int          TO    = 16;
  localparam int          DEPTH = 8;
  localparam logic [31:0] WADR  = 32'd160;
  localparam logic [31:0] EXP   = 32'h4202a40b;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        log_rd;
  logic        log_valid;
  logic [31:0] log_adr;
  logic [31:0] log_data;
  logic [3:0]  log_count;
  logic        log_overflow;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;
  logic [31:0] captured_data;
  logic [31:0] cycle_count;

  always #5 clk = ~clk;

  store_checker #(
    .WATCH_ADDR     (WADR),
    .EXPECT_DATA    (EXP),
    .TIMEOUT_CYCLES (TO),
    .LOG_DEPTH      (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .MemWrite      (MemWrite),
    .DataAdr       (DataAdr),
    .WriteData     (WriteData),
    .log_rd        (log_rd),
    .log_valid     (log_valid),
    .log_adr       (log_adr),
    .log_data      (log_data),
    .log_count     (log_count),
    .log_overflow  (log_overflow),
    .done          (done),
    .pass          (pass),
    .fail          (fail),
    .timeout       (timeout),
    .captured_data (captured_data),
    .cycle_count   (cycle_count)
  );

  typedef struct {
    logic        mw;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        rd;
    int          exp_cnt;
    logic        exp_ovf;
    logic        exp_to;
  } vec_t;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [63:0] sb_q[$];
  bit          m_run;
  bit          m_ovf;
  int          m_cyc;
  vec_t        tbl[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_status"}, 64'({done, pass, fail, timeout, log_valid, log_overflow}), 64'd0);
    check({tag, "_captured"}, 64'(captured_data), 64'd0);
    check({tag, "_cycles"}, 64'(cycle_count), 64'd0);
    check({tag, "_log_count"}, 64'(log_count), 64'd0);
    check({tag, "_log_head"}, {log_adr, log_data}, 64'd0);
  endtask

  // Called at a falling edge; drives one cycle and updates the model.
  task automatic step(input logic mw, input logic [31:0] adr, input logic [31:0] dat,
                      input logic rd);
    bit pop_ok;
    MemWrite  = mw;
    DataAdr   = adr;
    WriteData = dat;
    log_rd    = rd;
    pop_ok    = rd && (sb_q.size() != 0);
    if (pop_ok) begin
      check("head_adr", 64'(log_adr), 64'(sb_q[0][63:32]));
      check("head_data", 64'(log_data), 64'(sb_q[0][31:0]));
    end
    @(posedge clk);
    if (pop_ok) void'(sb_q.pop_front());
    if (m_run && mw) begin
      if (sb_q.size() < DEPTH) sb_q.push_back({adr, dat});
      else m_ovf = 1'b1;
    end
    if (m_run) begin
      m_cyc++;
      if (mw && adr == WADR) m_run = 1'b0;
      else if (m_cyc == TO) m_run = 1'b0;
    end
    @(negedge clk);
    MemWrite  = 1'b0;
    DataAdr   = 32'd0;
    WriteData = 32'd0;
    log_rd    = 1'b0;
    check("log_count", 64'(log_count), 64'(sb_q.size()));
    check("log_overflow", 64'(log_overflow), 64'(m_ovf));
    check("cycle_count", 64'(cycle_count), 64'(m_cyc));
    check("log_valid", 64'(log_valid), 64'(sb_q.size() != 0));
  endtask

  task automatic model_restart();
    sb_q.delete();
    m_ovf = 1'b0;
    m_cyc = 0;
    m_run = 1'b1;
  endtask

  // Reset pulse in the middle of the low phase, checked before any edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #3 reset = 1'b0;
    #1 check_zero(tag);
    #10 reset = 1'b1;
    @(negedge clk);
    model_restart();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 10; i++) begin
      tbl[i].mw      = 1'b1;
      tbl[i].adr     = 32'h10 + 32'(4 * i);
      tbl[i].dat     = 32'(i + 1);
      tbl[i].rd      = 1'b0;
      tbl[i].exp_cnt = (i + 1 > 8) ? 8 : i + 1;
      tbl[i].exp_ovf = (i >= 8);
      tbl[i].exp_to  = (i >= 15);
    end
    for (int i = 10; i < 18; i++) begin
      tbl[i].mw      = 1'b0;
      tbl[i].adr     = 32'd0;
      tbl[i].dat     = 32'd0;
      tbl[i].rd      = 1'b1;
      tbl[i].exp_cnt = 17 - i;
      tbl[i].exp_ovf = 1'b1;
      tbl[i].exp_to  = (i >= 15);
    end

    reset     = 1'b0;
    MemWrite  = 1'b0;
    DataAdr   = 32'd0;
    WriteData = 32'd0;
    log_rd    = 1'b0;
    #10 check_zero("reset");
    #12 reset = 1'b1;
    @(negedge clk);
    model_restart();
    check("t1_run_done", 64'(done), 64'd0);
    check("t1_run_cycles", 64'(cycle_count), 64'd0);

    // 1: matching result store on RUN cycle 5
    idle(5);
    step(1'b1, WADR, EXP, 1'b0);
    check("t1_pass", 64'({pass, fail, timeout, done}), 64'b1001);
    check("t1_captured", 64'(captured_data), 64'(EXP));
    check("t1_cycles", 64'(cycle_count), 64'd6);
    check("t1_log_count", 64'(log_count), 64'd1);
    check("t1_log_head", {log_adr, log_data}, {WADR, EXP});
    idle(3);
    check("t1_frozen", 64'(cycle_count), 64'd6);

    // 2: mismatching result store
    do_reset("t2_reset");
    step(1'b1, WADR, 32'h4202a40c, 1'b0);
    check("t2_fail", 64'({pass, fail, timeout, done}), 64'b0101);
    check("t2_captured", 64'(captured_data), 64'h4202a40c);

    // 3: timeout with no stores
    do_reset("t3_reset");
    idle(15);
    check("t3_not_yet", 64'({timeout, done}), 64'd0);
    step(1'b0, 32'd0, 32'd0, 1'b0);
    check("t3_timeout", 64'({pass, fail, timeout, done}), 64'b0011);
    check("t3_cycles", 64'(cycle_count), 64'd16);
    check("t3_empty", 64'({log_valid, log_count}), 64'd0);

    // 4: table-driven overflow and in-order drain
    do_reset("t4_reset");
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].mw, tbl[i].adr, tbl[i].dat, tbl[i].rd);
      check($sformatf("t4_count_%0d", i), 64'(log_count), 64'(tbl[i].exp_cnt));
      check($sformatf("t4_ovf_%0d", i), 64'(log_overflow), 64'(tbl[i].exp_ovf));
      check($sformatf("t4_to_%0d", i), 64'(timeout), 64'(tbl[i].exp_to));
    end

    // Push+pop while empty, then while full, then push while full
    do_reset("t7_reset");
    step(1'b1, 32'h200, 32'ha0, 1'b1);
    check("t7_empty_pushpop", 64'(log_count), 64'd1);
    for (int k = 1; k < 8; k++) step(1'b1, 32'h200 + 32'(4 * k), 32'(k), 1'b0);
    check("t7_full", 64'(log_count), 64'd8);
    step(1'b1, 32'h300, 32'hbb, 1'b1);
    check("t7_full_pushpop", 64'({log_overflow, log_count}), 64'd8);
    check("t7_head_after", {log_adr, log_data}, {32'h204, 32'd1});
    step(1'b1, 32'h304, 32'hcc, 1'b0);
    check("t7_drop", 64'({log_overflow, log_count}), 64'h18);
    for (int k = 0; k < 8; k++) step(1'b0, 32'd0, 32'd0, 1'b1);

    // 5: result store on the timeout edge, then later stores ignored
    do_reset("t5_reset");
    idle(15);
    step(1'b1, WADR, EXP, 1'b0);
    check("t5_pass", 64'({pass, fail, timeout, done}), 64'b1001);
    check("t5_cycles", 64'(cycle_count), 64'd16);
    step(1'b1, WADR, 32'hdead, 1'b0);
    step(1'b1, 32'h40, 32'h1, 1'b0);
    idle(3);
    check("t5_sticky", 64'({pass, fail, timeout, done}), 64'b1001);
    check("t5_captured", 64'(captured_data), 64'(EXP));
    check("t5_log_count", 64'(log_count), 64'd1);

    // 6: asynchronous reset after PASS, then rerun mismatch
    do_reset("t6_reset");
    step(1'b1, WADR, 32'h4202a40c, 1'b0);
    check("t6_fail", 64'({pass, fail, timeout, done}), 64'b0101);
    check("t6_captured", 64'(captured_data), 64'h4202a40c);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
